// File: rtl/pc_next_seq_pkg.sv
// Shared types and constants for the next-PC sequencer.
// Latency: none (declarations only).
// Backpressure: n/a.
package pc_next_seq_pkg;

  // Sequencer states; the 2-bit encoding is relied on by the state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_TRAP = 2'd3
  } state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int unsigned PC_INC       = 4;

endpackage

// File: rtl/pc_next_seq_if.sv
// Fetch-request bundle: PC offered to the IFU under a valid/ready handshake.
// Latency: wires only.
// Backpressure: master holds valid and pc stable until ready is seen.
interface pc_next_seq_if #(
  parameter int XLEN = 32
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] pc;

  modport master (output ifu_req_valid, output pc, input ifu_req_ready);
  modport slave  (input ifu_req_valid, input pc, output ifu_req_ready);
endinterface

// File: rtl/pc_next_seq_target_adder.sv
// Next-PC target: operand selects, add, jalr bit-0 clear, misalign detect.
// Latency: combinational.
// Backpressure: n/a.
module pc_target_adder
  import pc_next_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            a_src,
  input  logic            b_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum;

  // Select operands, add modulo 2^XLEN, clear bit 0 for register-relative jumps.
  always_comb begin
    op_a   = a_src ? imm : XLEN'(PC_INC);
    op_b   = b_src ? rs1 : pc;
    sum    = op_a + op_b;
    target = sum;
    if (b_src) begin
      target[0] = 1'b0;
    end
    // Instructions are 4-byte aligned; any low bit set after the clear traps.
    misaligned = |target[1:0];
  end

endmodule

// File: rtl/pc_next_seq.sv
// Holds the architectural PC, offers it to fetch, and advances it on commit.
// Latency: new PC offered the cycle after commit; 2 cycles/instr minimum.
// Backpressure: request held (never withdrawn) until ifu_req_ready; commit only seen in EXEC.
module pc_next_seq
  import pc_next_seq_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  parameter int              CNT_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pc_a_src,
  input  logic                 pc_b_src,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      rs1,
  input  logic                 commit,
  pc_next_seq_if.master        ifu,
  output logic                 misalign,
  output logic [XLEN-1:0]      misalign_addr,
  output logic [CNT_W-1:0]     instret
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             misalign_q, misalign_d;
  logic [XLEN-1:0]  misalign_addr_q, misalign_addr_d;
  logic             ifu_req_valid_q, ifu_req_valid_d;

  logic [XLEN-1:0]  target;
  logic             target_misaligned;

  pc_target_adder #(.XLEN(XLEN)) u_adder (
    .a_src      (pc_a_src),
    .b_src      (pc_b_src),
    .imm        (imm),
    .rs1        (rs1),
    .pc         (pc_q),
    .target     (target),
    .misaligned (target_misaligned)
  );

  // Next-state and datapath updates; operands are only looked at on EXEC & commit.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instret_d       = instret_q;
    misalign_d      = misalign_q;
    misalign_addr_d = misalign_addr_q;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (ifu.ifu_req_ready) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit) begin
          if (target_misaligned) begin
            misalign_d      = 1'b1;
            misalign_addr_d = target;
            state_d         = ST_TRAP;
          end else begin
            pc_d      = target;
            instret_d = instret_q + 1'b1;
            state_d   = ST_REQ;
          end
        end
      end
      default: state_d = ST_TRAP;  // trap is sticky until reset
    endcase

    // Valid comes straight from a flop so fetch sees a glitch-free request.
    ifu_req_valid_d = (state_d == ST_REQ);
  end

  // State and architectural registers; reset returns everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      instret_q       <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      ifu_req_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instret_q       <= instret_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
      ifu_req_valid_q <= ifu_req_valid_d;
    end
  end

  assign ifu.ifu_req_valid = ifu_req_valid_q;
  assign ifu.pc            = pc_q;
  assign misalign          = misalign_q;
  assign misalign_addr     = misalign_addr_q;
  assign instret           = instret_q;

endmodule

// File: tb/tb_pc_next_seq.sv
// Bench for pc_next_seq: vector table of committed instructions plus
// hand-written sequences for backpressure, traps and asynchronous reset.
module tb_pc_next_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        a_src;
  logic        b_src;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        commit;
  logic        misalign;
  logic [31:0] misalign_addr;
  logic [63:0] instret;

  int checks;
  int errors;

  pc_next_seq_if #(.XLEN(32)) ifu_bus ();

  pc_next_seq #(.XLEN(32), .RESET_PC(RST_PC), .CNT_W(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_a_src      (a_src),
    .pc_b_src      (b_src),
    .imm           (imm),
    .rs1           (rs1),
    .commit        (commit),
    .ifu           (ifu_bus),
    .misalign      (misalign),
    .misalign_addr (misalign_addr),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        a_src;
    logic        b_src;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_pc;
    logic [63:0] exp_instret;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic a, input logic b, input logic [31:0] i,
                              input logic [31:0] r, input logic [31:0] p,
                              input logic [63:0] n);
    vec_t v;
    v.a_src = a; v.b_src = b; v.imm = i; v.rs1 = r; v.exp_pc = p; v.exp_instret = n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a fetch request, accept it, and commit in EXEC.
  task automatic do_instr(input string nm, input logic a, input logic b,
                          input logic [31:0] i, input logic [31:0] r);
    int n;
    n = 0;
    while (ifu_bus.ifu_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (ifu_bus.ifu_req_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_req_timeout actual=0 expected=1", nm);
    end
    ifu_bus.ifu_req_ready = 1'b1;
    tick();
    ifu_bus.ifu_req_ready = 1'b0;
    chk({nm, "_exec_valid"}, {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
    a_src  = a;
    b_src  = b;
    imm    = i;
    rs1    = r;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    a_src  = 1'($urandom);
    b_src  = 1'($urandom);
    imm    = $urandom;
    rs1    = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    a_src = 1'b0; b_src = 1'b0; imm = '0; rs1 = '0; commit = 1'b0;
    ifu_bus.ifu_req_ready = 1'b0;

    // Straight-line program from the reset PC, ending with an address wrap.
    vecs[0] = mk(1'b0, 1'b0, 32'h0,         32'h0,         32'h8000_0004, 64'd1);
    vecs[1] = mk(1'b0, 1'b0, 32'h0,         32'h0,         32'h8000_0008, 64'd2);
    vecs[2] = mk(1'b1, 1'b0, 32'h0000_0008, 32'h0,         32'h8000_0010, 64'd3);
    vecs[3] = mk(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'h8000_0008, 64'd4);
    vecs[4] = mk(1'b1, 1'b1, 32'h0000_0004, 32'h8000_1001, 32'h8000_1004, 64'd5);
    vecs[5] = mk(1'b0, 1'b1, 32'h0,         32'h1234_5678, 32'h1234_567C, 64'd6);
    vecs[6] = mk(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'hFFFF_FFFC, 64'd7);
    vecs[7] = mk(1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_0000, 64'd8);

    // Reset values while reset is held.
    tick();
    tick();
    chk("rst_pc",       {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
    chk("rst_valid",    {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
    chk("rst_instret",  instret, 64'd0);
    chk("rst_misalign", {63'd0, misalign}, 64'd0);
    chk("rst_maddr",    {32'd0, misalign_addr}, 64'd0);

    // Release: one IDLE bubble, then the request appears.
    ifu_bus.ifu_req_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk("bubble_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
    tick();
    chk("first_req_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd1);
    chk("first_req_pc",    {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
    ifu_bus.ifu_req_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      do_instr($sformatf("v%0d", i), vecs[i].a_src, vecs[i].b_src, vecs[i].imm, vecs[i].rs1);
      chk($sformatf("v%0d_pc", i),       {32'd0, ifu_bus.pc}, {32'd0, vecs[i].exp_pc});
      chk($sformatf("v%0d_instret", i),  instret, vecs[i].exp_instret);
      chk($sformatf("v%0d_misalign", i), {63'd0, misalign}, 64'd0);
      chk($sformatf("v%0d_valid", i),    {63'd0, ifu_bus.ifu_req_valid}, 64'd1);
    end

    // Backpressure: request held 5 cycles, commit pulses in REQ ignored.
    a_src = 1'b1; b_src = 1'b0; imm = 32'h0000_0100; commit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d_valid", i), {63'd0, ifu_bus.ifu_req_valid}, 64'd1);
      chk($sformatf("bp%0d_pc", i),    {32'd0, ifu_bus.pc}, 64'd0);
    end
    commit = 1'b0;
    chk("bp_instret", instret, 64'd8);
    do_instr("bp_seq", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("bp_seq_pc",      {32'd0, ifu_bus.pc}, 64'h4);
    chk("bp_seq_instret", instret, 64'd9);

    // Reset in the middle of EXEC.
    ifu_bus.ifu_req_ready = 1'b1;
    tick();
    ifu_bus.ifu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rexec_pc",      {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
    chk("rexec_instret", instret, 64'd0);
    chk("rexec_valid",   {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
    tick();
    rst = 1'b0;

    // Misaligned branch target: sticky trap, inputs ignored afterwards.
    do_instr("mis", 1'b1, 1'b0, 32'h0000_0002, 32'h0);
    chk("mis_flag",    {63'd0, misalign}, 64'd1);
    chk("mis_addr",    {32'd0, misalign_addr}, 64'h8000_0002);
    chk("mis_pc",      {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
    chk("mis_instret", instret, 64'd0);
    chk("mis_valid",   {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
    ifu_bus.ifu_req_ready = 1'b1;
    commit = 1'b1; a_src = 1'b0; b_src = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("trap%0d_valid", i),   {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
      chk($sformatf("trap%0d_pc", i),      {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
      chk($sformatf("trap%0d_instret", i), instret, 64'd0);
    end
    chk("trap_flag_held", {63'd0, misalign}, 64'd1);
    commit = 1'b0;
    ifu_bus.ifu_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("trap_rst_flag", {63'd0, misalign}, 64'd0);
    chk("trap_rst_addr", {32'd0, misalign_addr}, 64'd0);
    tick();
    rst = 1'b0;

    // jalr whose target is misaligned even after bit 0 is cleared.
    do_instr("jmis", 1'b1, 1'b1, 32'h0, 32'h8000_0003);
    chk("jmis_flag", {63'd0, misalign}, 64'd1);
    chk("jmis_addr", {32'd0, misalign_addr}, 64'h8000_0002);
    chk("jmis_pc",   {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset asserted while a request is pending drops valid without a clock.
    do_instr("rreq", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rreq_pre_pc",    {32'd0, ifu_bus.pc}, 64'h8000_0004);
    chk("rreq_pre_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("rreq_valid", {63'd0, ifu_bus.ifu_req_valid}, 64'd0);
    chk("rreq_pc",    {32'd0, ifu_bus.pc}, {32'd0, RST_PC});
    tick();
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
